// File: rtl/spi_reg_bank.sv
// Register bank on the SPI slave's parallel side. Each register has a shadow copy
// that SPI writes and reads, and an active copy that the motor datapath sees.
module spi_reg_bank #(
  parameter int                DATA_W      = 16,
  parameter int                NUM_REGS    = 4,
  parameter int                ADDR_W      = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter bit                AUTO_COMMIT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         re,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic                         commit,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rvalid,
  output logic                         wr_err,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [7:0]                   commit_cnt
);

  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];

  logic              waddr_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_mux;

  assign waddr_ok = 32'(waddr) < NUM_REGS;
  assign wr_ok    = we && waddr_ok;

  // Out-of-range read addresses match no register and fall through to zero.
  always_comb begin
    // NOTE: default assigned first so every path drives rd_mux and no latch is inferred.
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(raddr) == i) rd_mux = shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register arrays are reset, not left uninitialised, because the motor
      // datapath consumes active copies directly and must never see X after reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VAL;
        active[i] <= RESET_VAL;
      end
      rdata      <= '0;
      rvalid     <= 1'b0;
      wr_err     <= 1'b0;
      commit_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments make every read of shadow here see the pre-edge
      // value, which is what gives read-before-write and commit-before-write ordering.
      rvalid <= re;
      if (re) rdata <= rd_mux;
      wr_err <= we && !waddr_ok;
      if (commit) commit_cnt <= commit_cnt + 8'd1;

      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit) active[i] <= shadow[i];
        if (wr_ok && 32'(waddr) == i) begin
          shadow[i] <= wdata;
          // Later assignment wins, so in legacy mode a same-cycle write beats the commit.
          if (AUTO_COMMIT) active[i] <= wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = active[g];
  end

endmodule
